// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register front end: synchronizes the SPI pins to clk,
// decodes 16-bit write frames and holds the PWM/output stage control registers.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_commit,
  output logic       txn_drop
);

  localparam int REG_SLOTS = (NUM_REGS > 5) ? NUM_REGS : 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;
  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_rise;

  state_t      state;
  logic [4:0]  bit_count;
  logic [15:0] shift_reg;
  logic        armed;
  logic        frame_valid;
  logic [7:0]  regs [REG_SLOTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi_in};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_in};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  assign frame_valid = (bit_count == 5'd16) && shift_reg[15] &&
                       (int'({25'd0, shift_reg[14:8]}) < NUM_REGS);

  // armed is only set once synced nCS is seen high, so a frame already in
  // progress when reset releases is ignored until chip select deasserts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_count  <= '0;
      shift_reg  <= '0;
      armed      <= 1'b0;
      txn_commit <= 1'b0;
      txn_drop   <= 1'b0;
      for (int i = 0; i < REG_SLOTS; i++) regs[i] <= '0;
    end else begin
      txn_commit <= 1'b0;
      txn_drop   <= 1'b0;
      if (ncs_s) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && !ncs_s) begin
            state     <= SHIFT;
            bit_count <= '0;
            shift_reg <= '0;
            armed     <= 1'b0;
          end
        end
        SHIFT: begin
          // nCS rise takes priority, so an SCLK edge in the same cycle is not counted
          if (ncs_rise) begin
            state <= COMMIT;
            if (frame_valid) begin
              for (int i = 0; i < NUM_REGS; i++)
                if (shift_reg[14:8] == 7'(i)) regs[i] <= shift_reg[7:0];
              txn_commit <= 1'b1;
            end else begin
              txn_drop <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_count != 5'd17) bit_count <= bit_count + 5'd1;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: vector table, hand-written
// corner sequences and random frames against a register-map model.
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_in;
  logic       copi_in;
  logic       ncs_in;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       txn_commit;
  logic       txn_drop;

  typedef struct {
    logic [16:0] bits;
    int          nbits;
    int          half;
    int          gap;
    logic        exp_commit;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         commit_cnt = 0;
  int         drop_cnt = 0;
  logic [7:0] mdl [5];
  logic [7:0] dut_regs [5];
  vec_t       vecs [7];

  spi_reg_peripheral #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk),
    .rst(rst),
    .sclk_in(sclk_in),
    .copi_in(copi_in),
    .ncs_in(ncs_in),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .txn_commit(txn_commit),
    .txn_drop(txn_drop)
  );

  always #5 clk = ~clk;

  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  always @(negedge clk) begin
    if (txn_commit === 1'b1) commit_cnt++;
    if (txn_drop === 1'b1) drop_cnt++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++)
      check_output($sformatf("%s reg%0d", tag, i), {24'd0, dut_regs[i]}, {24'd0, mdl[i]});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start(input int half);
    ncs_in  = 1'b0;
    copi_in = 1'b0;
    wait_cycles(half);
  endtask

  task automatic spi_bit(input logic b, input int half);
    copi_in = b;
    wait_cycles(half);
    sclk_in = 1'b1;
    wait_cycles(half);
    sclk_in = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [16:0] bits, input int nbits, input int half, input int gap);
    spi_start(half);
    for (int i = nbits - 1; i >= 0; i--) spi_bit(bits[i], half);
    wait_cycles(half);
    ncs_in = 1'b1;
    wait_cycles(gap);
  endtask

  // Register-map model: only a full 16-bit write to an implemented address lands.
  function automatic logic model_write(input logic [16:0] bits, input int nbits);
    int a;
    a = int'(bits[14:8]);
    if (nbits == 16 && bits[15] && a < 5) begin
      mdl[a] = bits[7:0];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int c0;
    int d0;
    logic [16:0] rbits;
    int   rn;
    int   sel;
    logic exp;

    vecs[0] = '{17'h08480, 16, 3, 8, 1'b1};
    vecs[1] = '{17'h084FF, 16, 4, 8, 1'b1};
    vecs[2] = '{17'h00130, 16, 3, 8, 1'b0};
    vecs[3] = '{17'h08555, 16, 3, 8, 1'b0};
    vecs[4] = '{17'h04055, 15, 3, 8, 1'b0};
    vecs[5] = '{17'h10233, 17, 3, 8, 1'b0};
    vecs[6] = '{17'h08307, 16, 5, 8, 1'b1};
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;

    rst = 1'b1; sclk_in = 1'b0; copi_in = 1'b0; ncs_in = 1'b1;
    wait_cycles(2);
    check_regs("reset");
    check_output("reset txn_commit", {31'd0, txn_commit}, 32'd0);
    check_output("reset txn_drop", {31'd0, txn_drop}, 32'd0);
    rst = 1'b0;
    wait_cycles(5);

    // Exact commit latency for 0x80F0, counted from the nCS pin rise
    c0 = commit_cnt; d0 = drop_cnt;
    spi_start(3);
    for (int i = 15; i >= 0; i--) spi_bit(logic'((32'h80F0 >> i) & 1), 3);
    wait_cycles(3);
    ncs_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("latency edge2 commit", {31'd0, txn_commit}, 32'd0);
    check_output("latency edge2 reg0", {24'd0, en_reg_out_7_0}, 32'h00);
    @(posedge clk); #1;
    check_output("latency edge3 commit", {31'd0, txn_commit}, 32'd1);
    check_output("latency edge3 reg0", {24'd0, en_reg_out_7_0}, 32'hF0);
    @(posedge clk); #1;
    check_output("latency edge4 commit", {31'd0, txn_commit}, 32'd0);
    void'(model_write(17'h080F0, 16));
    wait_cycles(5);
    check_output("0x80F0 commit count", 32'(commit_cnt - c0), 32'd1);
    check_output("0x80F0 drop count", 32'(drop_cnt - d0), 32'd0);
    check_regs("0x80F0");

    for (int v = 0; v < 7; v++) begin
      c0 = commit_cnt; d0 = drop_cnt;
      apply_stimulus(vecs[v].bits, vecs[v].nbits, vecs[v].half, vecs[v].gap);
      void'(model_write(vecs[v].bits, vecs[v].nbits));
      check_output($sformatf("vec%0d commit", v), 32'(commit_cnt - c0), {31'd0, vecs[v].exp_commit});
      check_output($sformatf("vec%0d drop", v), 32'(drop_cnt - d0), {31'd0, ~vecs[v].exp_commit});
      check_regs($sformatf("vec%0d", v));
    end

    // Reset after bit 8 of 0x8233; the rest of that frame must be ignored
    c0 = commit_cnt; d0 = drop_cnt;
    spi_start(3);
    for (int i = 15; i >= 8; i--) spi_bit(logic'((32'h8233 >> i) & 1), 3);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(logic'((32'h8233 >> i) & 1), 3);
    wait_cycles(3);
    ncs_in = 1'b1;
    wait_cycles(8);
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    check_output("midreset commit", 32'(commit_cnt - c0), 32'd0);
    check_output("midreset drop", 32'(drop_cnt - d0), 32'd0);
    check_regs("midreset");
    c0 = commit_cnt;
    apply_stimulus(17'h08233, 16, 3, 8);
    void'(model_write(17'h08233, 16));
    check_output("post-reset write commit", 32'(commit_cnt - c0), 32'd1);
    check_regs("post-reset write");

    // Back-to-back frames at minimum SCLK with a 3-cycle nCS gap
    c0 = commit_cnt; d0 = drop_cnt;
    apply_stimulus(17'h081AA, 16, 3, 3);
    apply_stimulus(17'h08355, 16, 3, 8);
    void'(model_write(17'h081AA, 16));
    void'(model_write(17'h08355, 16));
    check_output("back-to-back commit", 32'(commit_cnt - c0), 32'd2);
    check_output("back-to-back drop", 32'(drop_cnt - d0), 32'd0);
    check_regs("back-to-back");

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 5));
      rn = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      rbits = {1'($urandom), 1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 6)), 8'($urandom)};
      c0 = commit_cnt; d0 = drop_cnt;
      apply_stimulus(rbits, rn, int'($urandom_range(3, 5)), int'($urandom_range(3, 6)));
      wait_cycles(5);
      exp = model_write(rbits, rn);
      check_output($sformatf("rand%0d commit", n), 32'(commit_cnt - c0), {31'd0, exp});
      check_output($sformatf("rand%0d drop", n), 32'(drop_cnt - d0), {31'd0, ~exp});
      check_regs($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
